// File: rtl/frame_bank_ctrl_if.sv
// rtl/frame_bank_ctrl_if.sv - capture/display handshake bundle for the triple-buffer bank controller
interface frame_bank_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             capture_en;
  logic             wr_frame_start;
  logic             wr_frame_end;
  logic             rd_frame_start;
  logic [1:0]       wr_bank;
  logic [1:0]       rd_bank;
  logic             wr_en;
  logic             rd_valid;
  logic             frame_ready;
  logic [CNT_W-1:0] frames_written;
  logic [CNT_W-1:0] frames_dropped;

  // Source side: camera/HDMI timing plus control, observes bank state
  modport master (
    output capture_en, wr_frame_start, wr_frame_end, rd_frame_start,
    input  wr_bank, rd_bank, wr_en, rd_valid, frame_ready,
           frames_written, frames_dropped
  );

  // Controller side
  modport slave (
    input  capture_en, wr_frame_start, wr_frame_end, rd_frame_start,
    output wr_bank, rd_bank, wr_en, rd_valid, frame_ready,
           frames_written, frames_dropped
  );
endinterface

// File: rtl/frame_bank_ctrl.sv
// rtl/frame_bank_ctrl.sv - triple-buffer bank arbitration between camera writer and HDMI reader
module frame_bank_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             pixel_clk,
  input  logic             rst,
  frame_bank_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       wr_bank_q, wr_bank_d;
  logic [1:0]       rd_bank_q, rd_bank_d;
  logic [1:0]       spare_bank_q, spare_bank_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_valid_q, rd_valid_d;
  logic             frame_ready_q, frame_ready_d;
  logic [CNT_W-1:0] frames_written_q, frames_written_d;
  logic [CNT_W-1:0] frames_dropped_q, frames_dropped_d;

  logic commit;
  logic rd_take;

  // A frame that completes in the same cycle the reader asks for one is handed
  // straight to the reader, so a pending frame is not required for that case.
  always_comb begin
    commit  = (state_q == CAPTURE) && bus.wr_frame_end;
    rd_take = bus.rd_frame_start && (frame_ready_q || commit);
  end

  // Next-state, bank rotation and statistics
  always_comb begin
    state_d          = state_q;
    wr_bank_d        = wr_bank_q;
    rd_bank_d        = rd_bank_q;
    spare_bank_d     = spare_bank_q;
    rd_valid_d       = rd_valid_q;
    frame_ready_d    = frame_ready_q;
    frames_written_d = frames_written_q;
    frames_dropped_d = frames_dropped_q;

    unique case (state_q)
      IDLE: begin
        if (bus.capture_en) state_d = ARMED;
      end
      ARMED: begin
        if (bus.wr_frame_start)   state_d = CAPTURE;
        else if (!bus.capture_en) state_d = IDLE;
      end
      CAPTURE: begin
        // Without an end pulse a start pulse just restarts the frame in place.
        // capture_en only matters once the current frame has committed.
        if (bus.wr_frame_end) begin
          if (!bus.capture_en)         state_d = IDLE;
          else if (bus.wr_frame_start) state_d = CAPTURE;
          else                         state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit && rd_take) begin
      // Fresh frame goes directly to display; old display bank becomes spare.
      rd_bank_d     = wr_bank_q;
      wr_bank_d     = spare_bank_q;
      spare_bank_d  = rd_bank_q;
      frame_ready_d = 1'b0;
    end else if (commit) begin
      wr_bank_d     = spare_bank_q;
      spare_bank_d  = wr_bank_q;
      frame_ready_d = 1'b1;
      if (frame_ready_q && frames_dropped_q != CNT_MAX)
        frames_dropped_d = frames_dropped_q + CNT_W'(1);
    end else if (rd_take) begin
      rd_bank_d     = spare_bank_q;
      spare_bank_d  = rd_bank_q;
      frame_ready_d = 1'b0;
    end

    if (rd_take) rd_valid_d = 1'b1;

    if (commit && frames_written_q != CNT_MAX)
      frames_written_d = frames_written_q + CNT_W'(1);

    wr_en_d = (state_d == CAPTURE);
  end

  // State and output registers; reset overrides every input
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q          <= IDLE;
      wr_bank_q        <= 2'd0;
      rd_bank_q        <= 2'd1;
      spare_bank_q     <= 2'd2;
      wr_en_q          <= 1'b0;
      rd_valid_q       <= 1'b0;
      frame_ready_q    <= 1'b0;
      frames_written_q <= '0;
      frames_dropped_q <= '0;
    end else begin
      state_q          <= state_d;
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      spare_bank_q     <= spare_bank_d;
      wr_en_q          <= wr_en_d;
      rd_valid_q       <= rd_valid_d;
      frame_ready_q    <= frame_ready_d;
      frames_written_q <= frames_written_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  // Drive the bundle from registered state only
  always_comb begin
    bus.wr_bank        = wr_bank_q;
    bus.rd_bank        = rd_bank_q;
    bus.wr_en          = wr_en_q;
    bus.rd_valid       = rd_valid_q;
    bus.frame_ready    = frame_ready_q;
    bus.frames_written = frames_written_q;
    bus.frames_dropped = frames_dropped_q;
  end

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// tb/tb_frame_bank_ctrl.sv - scoreboard bench for frame_bank_ctrl
module tb_frame_bank_ctrl;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [1:0]       wb;
    logic [1:0]       rb;
    logic             en;
    logic             v;
    logic             fr;
    logic [CNT_W-1:0] w;
    logic [CNT_W-1:0] d;
  } snap_t;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;

  frame_bank_ctrl_if #(.CNT_W(CNT_W)) bus ();

  frame_bank_ctrl #(.CNT_W(CNT_W)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  snap_t exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  done = 1'b0;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_end   = 1'b0;
    bus.rd_frame_start = 1'b0;
  endtask

  task automatic expect_out(input string name, input int wb, input int rb, input int en,
                            input int v, input int fr, input int w, input int d);
    snap_t e;
    e.wb = 2'(wb);
    e.rb = 2'(rb);
    e.en = 1'(en);
    e.v  = 1'(v);
    e.fr = 1'(fr);
    e.w  = CNT_W'(w);
    e.d  = CNT_W'(d);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  always @(negedge pixel_clk) begin
    snap_t e;
    snap_t a;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{bus.wr_bank, bus.rd_bank, bus.wr_en, bus.rd_valid, bus.frame_ready,
             bus.frames_written, bus.frames_dropped};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got wr=%0d rd=%0d en=%0d v=%0d fr=%0d w=%0d d=%0d, want wr=%0d rd=%0d en=%0d v=%0d fr=%0d w=%0d d=%0d",
                 nm, a.wb, a.rb, a.en, a.v, a.fr, a.w, a.d, e.wb, e.rb, e.en, e.v, e.fr, e.w, e.d);
      end
    end
    if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.capture_en = 1'b0;
    tick();
    rst = 1'b0;
    expect_out("reset", 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.capture_en     = 1'b0;
    bus.wr_frame_start = 1'b0;
    bus.wr_frame_end   = 1'b0;
    bus.rd_frame_start = 1'b0;

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    expect_out("armed", 0, 1, 0, 0, 0, 0, 0);
    bus.wr_frame_start = 1'b1;
    tick();
    expect_out("wr_en_c1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      expect_out($sformatf("wr_en_c%0d", i), 0, 1, 1, 0, 0, 0, 0);
    end
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("commit1", 2, 1, 0, 0, 1, 1, 0);
    n_cmp++;
    if (bus.rd_bank === bus.wr_bank) begin
      n_bad++;
      $display("FAIL commit1_distinct: rd_bank=%0d equals wr_bank=%0d", bus.rd_bank, bus.wr_bank);
    end
    bus.rd_frame_start = 1'b1;
    tick();
    expect_out("display1", 2, 0, 0, 1, 0, 1, 0);
    n_cmp++;
    if (bus.rd_bank === bus.wr_bank) begin
      n_bad++;
      $display("FAIL display1_distinct: rd_bank=%0d equals wr_bank=%0d", bus.rd_bank, bus.wr_bank);
    end
    bus.rd_frame_start = 1'b1;
    tick();
    expect_out("rd_no_frame", 2, 0, 0, 1, 0, 1, 0);
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("commit_into_spare1", 1, 0, 0, 1, 1, 2, 0);

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("drop_first", 2, 1, 0, 0, 1, 1, 0);
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("drop_second", 0, 1, 0, 0, 1, 2, 1);

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_end   = 1'b1;
    bus.rd_frame_start = 1'b1;
    tick();
    expect_out("same_cycle_rotate", 2, 0, 0, 1, 0, 1, 0);
    n_cmp++;
    if (bus.rd_bank === bus.wr_bank || bus.rd_bank > 2'd2 || bus.wr_bank > 2'd2) begin
      n_bad++;
      $display("FAIL same_cycle_distinct: rd_bank=%0d wr_bank=%0d", bus.rd_bank, bus.wr_bank);
    end

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    bus.capture_en = 1'b0;
    tick();
    tick();
    expect_out("no_abort", 0, 1, 1, 0, 0, 0, 0);
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("late_commit", 2, 1, 0, 0, 1, 1, 0);
    bus.wr_frame_start = 1'b1;
    tick();
    expect_out("idle_ignores_start", 2, 1, 0, 0, 1, 1, 0);
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("idle_ignores_end", 2, 1, 0, 0, 1, 1, 0);

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.wr_frame_end = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_mid_capture", 0, 1, 0, 0, 0, 0, 0);
    bus.wr_frame_end = 1'b1;
    tick();
    expect_out("end_after_rst", 0, 1, 0, 0, 0, 0, 0);

    do_reset();
    bus.capture_en = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    bus.wr_frame_start = 1'b1;
    tick();
    expect_out("restart", 0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      bus.wr_frame_start = 1'b1;
      bus.wr_frame_end   = 1'b1;
      tick();
      if (k == 1 || k == 15 || k == 16 || k == 20)
        expect_out($sformatf("sat_k%0d", k), (k % 2 == 1) ? 2 : 0, 1, 1, 0, 1,
                   (k > 15) ? 15 : k, (k - 1 > 15) ? 15 : k - 1);
    end
    n_cmp++;
    if (bus.rd_bank === bus.wr_bank) begin
      n_bad++;
      $display("FAIL sat_distinct: rd_bank=%0d equals wr_bank=%0d", bus.rd_bank, bus.wr_bank);
    end

    tick();
    done = 1'b1;
    repeat (3) @(posedge pixel_clk);
    $display("FAIL summary_timeout: monitor did not finish");
    $fatal(1);
  end
endmodule
